// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Shares one single-ported data memory between two requesters (m0: SISC
// load/store path, m1: test/loader port). Each requester issues a clocked
// req/ack transaction; the arbiter grants one transaction at a time with
// round-robin priority and sequences it into the memory's timing:
//   - reads are combinational on dm_read_addr, captured one cycle after grant
//   - writes commit on the falling edge of dm_we (high for exactly one cycle)
//
// Ports:
//   clk, rst            system clock (posedge), async active-high reset
//   mX_req/we/addr/wdata requester X transaction inputs (held until ack)
//   mX_ack              requester X one-cycle completion strobe
//   mX_rdata            requester X read data, valid while mX_ack=1 and held
//                       until that requester's next read completes
//   dm_read_addr        memory read address
//   dm_write_addr/data  memory write address/data (not reset)
//   dm_we               memory write enable, commit on falling edge
//   dm_read_data        memory read data
// -----------------------------------------------------------------------------
module dm_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_rdata_o,

    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_rdata_o,

    output logic [AW-1:0] dm_read_addr_o,
    output logic [AW-1:0] dm_write_addr_o,
    output logic [DW-1:0] dm_write_data_o,
    output logic          dm_we_o,
    input  logic [DW-1:0] dm_read_data_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WR_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;       // 0: m0 wins a tie, 1: m1 wins a tie
    logic          winner_q, winner_d;   // id of the requester in flight
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          dm_we_q, dm_we_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          gnt1;
    logic          gnt_we;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        winner_d   = winner_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        dm_we_d    = 1'b0;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        // m1 wins if it is the only requester, or on a tie when it holds prio.
        gnt1   = m1_req_i && (!m0_req_i || prio_q);
        gnt_we = gnt1 ? m1_we_i : m0_we_i;

        case (state_q)
            S_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    winner_d  = gnt1;
                    prio_d    = !gnt1;
                    rd_addr_d = gnt1 ? m1_addr_i : m0_addr_i;
                    wr_addr_d = gnt1 ? m1_addr_i : m0_addr_i;
                    wr_data_d = gnt1 ? m1_wdata_i : m0_wdata_i;
                    if (gnt_we) begin
                        // dm_we is registered, so raise it on the grant edge
                        // to have it high throughout WR_HI.
                        state_d = S_WR_HI;
                        dm_we_d = 1'b1;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                // Read data is captured and ack raised on the edge leaving RD,
                // so both are visible together during ACK.
                if (winner_q) begin
                    m1_rdata_d = dm_read_data_i;
                    m1_ack_d   = 1'b1;
                end else begin
                    m0_rdata_d = dm_read_data_i;
                    m0_ack_d   = 1'b1;
                end
                state_d = S_ACK;
            end
            S_WR_HI: begin
                // dm_we defaults low here; its fall at this edge commits the write.
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                if (winner_q) begin
                    m1_ack_d = 1'b1;
                end else begin
                    m0_ack_d = 1'b1;
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prio_q     <= 1'b0;
            winner_q   <= 1'b0;
            rd_addr_q  <= '0;
            dm_we_q    <= 1'b0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            winner_q   <= winner_d;
            rd_addr_q  <= rd_addr_d;
            dm_we_q    <= dm_we_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Write address/data are deliberately outside the reset: if reset lands
    // in WR_HI, dm_we falls asynchronously while these still hold the
    // in-flight values, so the memory commits a coherent write.
    always_ff @(posedge clk) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
    end

    assign m0_ack_o        = m0_ack_q;
    assign m1_ack_o        = m1_ack_q;
    assign m0_rdata_o      = m0_rdata_q;
    assign m1_rdata_o      = m1_rdata_q;
    assign dm_read_addr_o  = rd_addr_q;
    assign dm_write_addr_o = wr_addr_q;
    assign dm_write_data_o = wr_data_q;
    assign dm_we_o         = dm_we_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//
// Directed bench for dm_arbiter. A small behavioural memory reads
// combinationally and commits writes on the falling edge of dm_we. Requester
// transactions are queued per master; the run task drives them, follows the
// req/ack handshake, and records which requester was acked on which cycle.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] dm_read_addr, dm_write_addr;
    logic [DW-1:0] dm_write_data, dm_read_data;
    logic          dm_we;

    logic [DW-1:0] mem [0:255];
    bit            mem_armed = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];
    int   ack_ids[$];
    int   ack_cyc[$];
    int   we_cnt;
    int   dual_cnt;
    int   spur_cnt;

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .m0_req_i        (m0_req),
        .m0_we_i         (m0_we),
        .m0_addr_i       (m0_addr),
        .m0_wdata_i      (m0_wdata),
        .m0_ack_o        (m0_ack),
        .m0_rdata_o      (m0_rdata),
        .m1_req_i        (m1_req),
        .m1_we_i         (m1_we),
        .m1_addr_i       (m1_addr),
        .m1_wdata_i      (m1_wdata),
        .m1_ack_o        (m1_ack),
        .m1_rdata_o      (m1_rdata),
        .dm_read_addr_o  (dm_read_addr),
        .dm_write_addr_o (dm_write_addr),
        .dm_write_data_o (dm_write_data),
        .dm_we_o         (dm_we),
        .dm_read_data_i  (dm_read_data)
    );

    always #5 clk = ~clk;

    assign dm_read_data = mem[dm_read_addr[7:0]];

    always @(negedge dm_we) begin
        if (mem_armed) mem[dm_write_addr[7:0]] = dm_write_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] exp);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.exp = exp;
        return t;
    endfunction

    task automatic drive_head(input int m);
        if (m == 0) begin
            if (q0.size() > 0) begin
                m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
            end else begin
                m0_req = 1'b0;
            end
        end else begin
            if (q1.size() > 0) begin
                m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
            end else begin
                m1_req = 1'b0;
            end
        end
    endtask

    // Drives both queues until empty. Must be entered just after a posedge
    // with the arbiter in IDLE. A requester with more queued work keeps req
    // high into the next IDLE cycle (back-to-back issue).
    task automatic run(input int budget);
        int cyc;
        bit a0, a1;
        cyc = 0;
        ack_ids.delete(); ack_cyc.delete();
        we_cnt = 0; dual_cnt = 0; spur_cnt = 0;
        drive_head(0); drive_head(1);
        while ((q0.size() > 0 || q1.size() > 0) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            a0 = m0_ack; a1 = m1_ack;
            if (dm_we) we_cnt++;
            if (a0 && a1) dual_cnt++;
            if (a0) begin
                if (q0.size() == 0) spur_cnt++;
                else begin
                    ack_ids.push_back(0); ack_cyc.push_back(cyc);
                    $display("txn m0 we=%0d addr=%h cycle=%0d rdata=%h", q0[0].we, q0[0].addr, cyc, m0_rdata);
                    if (!q0[0].we) check_eq("m0_rdata", m0_rdata, q0[0].exp);
                end
            end
            if (a1) begin
                if (q1.size() == 0) spur_cnt++;
                else begin
                    ack_ids.push_back(1); ack_cyc.push_back(cyc);
                    $display("txn m1 we=%0d addr=%h cycle=%0d rdata=%h", q1[0].we, q1[0].addr, cyc, m1_rdata);
                    if (!q1[0].we) check_eq("m1_rdata", m1_rdata, q1[0].exp);
                end
            end
            @(posedge clk);
            #1;
            if (a0 && q0.size() > 0) begin void'(q0.pop_front()); drive_head(0); end
            if (a1 && q1.size() > 0) begin void'(q1.pop_front()); drive_head(1); end
        end
        check_eq("run_pending", q0.size() + q1.size(), 0);
        check_eq("dual_ack", dual_cnt, 0);
        check_eq("spurious_ack", spur_cnt, 0);
        q0.delete(); q1.delete();
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int acks, last;
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[2] = 32'h0000000A;
        mem[5] = 32'h00000055;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_m0_ack", m0_ack, 0);
        check_eq("rst_m1_ack", m1_ack, 0);
        check_eq("rst_m0_rdata", m0_rdata, 0);
        check_eq("rst_m1_rdata", m1_rdata, 0);
        check_eq("rst_dm_we", dm_we, 0);
        check_eq("rst_rd_addr", dm_read_addr, 0);
        mem_armed = 1'b1;
        rst = 1'b0;

        // 1. Single read by m0.
        q0.push_back(mk(0, 16'h0002, 32'h0, 32'h0000000A));
        run(20);
        check_eq("t1_n_acks", ack_ids.size(), 1);
        check_eq("t1_ack_cycle", ack_cyc[0], 3);
        check_eq("t1_we_cycles", we_cnt, 0);
        @(negedge clk);
        check_eq("t1_rdata_hold", m0_rdata, 32'h0000000A);
        check_eq("t1_m1_rdata", m1_rdata, 0);
        @(posedge clk); #1;

        // 2. m1 write then read-back, back to back.
        q1.push_back(mk(1, 16'h0010, 32'hDEADBEEF, 32'h0));
        q1.push_back(mk(0, 16'h0010, 32'h0, 32'hDEADBEEF));
        run(30);
        check_eq("t2_n_acks", ack_ids.size(), 2);
        check_eq("t2_id0", ack_ids[0], 1);
        check_eq("t2_id1", ack_ids[1], 1);
        check_eq("t2_wr_ack_cycle", ack_cyc[0], 4);
        check_eq("t2_rd_ack_cycle", ack_cyc[1], 7);
        check_eq("t2_we_cycles", we_cnt, 1);
        check_eq("t2_mem", mem[8'h10], 32'hDEADBEEF);

        // 3. Contention after reset, then alternation.
        pulse_reset();
        check_eq("t3_rst_m0_rdata", m0_rdata, 0);
        q0.push_back(mk(0, 16'h0002, 32'h0, 32'h0000000A));
        q1.push_back(mk(0, 16'h0010, 32'h0, 32'hDEADBEEF));
        run(30);
        check_eq("t3a_first", ack_ids[0], 0);
        check_eq("t3a_second", ack_ids[1], 1);
        check_eq("t3a_cyc0", ack_cyc[0], 3);
        check_eq("t3a_cyc1", ack_cyc[1], 6);
        q0.push_back(mk(0, 16'h0002, 32'h0, 32'h0000000A));
        run(20);
        q0.push_back(mk(0, 16'h0002, 32'h0, 32'h0000000A));
        q1.push_back(mk(0, 16'h0010, 32'h0, 32'hDEADBEEF));
        run(30);
        check_eq("t3b_first", ack_ids[0], 1);
        check_eq("t3b_second", ack_ids[1], 0);

        // 4. m0 back-to-back writes while m1 holds a read.
        pulse_reset();
        q0.push_back(mk(1, 16'h0020, 32'h11110001, 32'h0));
        q0.push_back(mk(1, 16'h0021, 32'h22220002, 32'h0));
        q1.push_back(mk(0, 16'h0010, 32'h0, 32'hDEADBEEF));
        run(40);
        check_eq("t4_n_acks", ack_ids.size(), 3);
        check_eq("t4_id0", ack_ids[0], 0);
        check_eq("t4_id1", ack_ids[1], 1);
        check_eq("t4_id2", ack_ids[2], 0);
        check_eq("t4_cyc1", ack_cyc[1], 7);
        check_eq("t4_cyc2", ack_cyc[2], 11);
        check_eq("t4_we_cycles", we_cnt, 2);
        check_eq("t4_mem20", mem[8'h20], 32'h11110001);
        check_eq("t4_mem21", mem[8'h21], 32'h22220002);

        // 5. Reset during WR_HI.
        m0_req = 1; m0_we = 1; m0_addr = 16'h0004; m0_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        check_eq("t5_we_in_wrhi", dm_we, 1);
        m0_req = 0;
        #1 rst = 1'b1;
        #1;
        check_eq("t5_we_async_drop", dm_we, 0);
        check_eq("t5_mem4", mem[8'h04], 32'h12345678);
        #1 rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) acks++;
        end
        check_eq("t5_no_ack", acks, 0);
        $display("txn m0 we=1 addr=0004 aborted by reset");
        @(posedge clk); #1;
        q0.push_back(mk(0, 16'h0005, 32'h0, 32'h00000055));
        run(20);
        check_eq("t5_mem5", mem[8'h05], 32'h00000055);

        // 6. m0 holds req two cycles past its ack.
        m0_req = 1; m0_we = 0; m0_addr = 16'h0002;
        acks = 0; last = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (m0_ack) begin
                acks++; last = c;
                $display("txn m0 we=0 addr=0002 cycle=%0d rdata=%h (held req)", c, m0_rdata);
            end
            if (m1_ack) acks += 100;
            @(posedge clk);
            #1;
            if (c == 5) m0_req = 0;
        end
        check_eq("t6_n_acks", acks, 2);
        check_eq("t6_last_ack", last, 6);
        check_eq("t6_rdata", m0_rdata, 32'h0000000A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
